// File: rtl/uart_word_loader.sv
// uart_word_loader: packs UART bytes into words and hands them to memory over valid/ready
module uart_word_loader #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter bit                BIG_ENDIAN  = 1'b1,
   parameter int                TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              debug_en_i,
   input  logic              rx_done_i,
   input  logic [7:0]        rx_data_i,
   output logic              req_o,
   output logic              wr_valid_o,
   input  logic              wr_ready_i,
   output logic [ADDR_W-1:0] w_addr,
   output logic [DATA_W-1:0] w_data,
   output logic              word_done_o,
   output logic [ADDR_W-1:0] word_cnt_o,
   output logic              timeout_o,
   output logic              overrun_o
);
   localparam int NB = DATA_W / 8;
   localparam int IW = $clog2(NB + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 2);
   typedef enum logic {IDLE, COLLECT} col_st_t;
   typedef enum logic {EMPTY, FULL} out_st_t;
   col_st_t           col_st_q, col_st_d;
   out_st_t           out_st_q, out_st_d;
   logic [IW-1:0]     idx_q, idx_d, pos;
   logic [DATA_W-1:0] asm_q, asm_d, asm_nxt, data_q, data_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
   logic              done_q, done_d, tflag_q, tflag_d, ovr_q, ovr_d;
   logic              start, byte_in, complete, accept, full, fire;
   always_comb begin
      start    = debug_en_i && col_st_q == IDLE;
      byte_in  = debug_en_i && rx_done_i;
      complete = byte_in && idx_q == IW'(NB - 1);
      accept   = out_st_q == FULL && wr_ready_i;
      // a word still pending at a download start is cleared, so the buffer counts as free
      full     = out_st_q == FULL && !start && !wr_ready_i;
      pos      = BIG_ENDIAN ? IW'(NB - 1) - idx_q : idx_q;
      asm_nxt  = (asm_q & ~(DATA_W'(8'hFF) << (8 * pos))) | (DATA_W'(rx_data_i) << (8 * pos));
      fire     = TIMEOUT_CYC != 0 && debug_en_i && !byte_in && idx_q != '0 &&
                 tmo_q + TW'(1) == TW'(TIMEOUT_CYC);
      col_st_d = debug_en_i ? COLLECT : IDLE;
      idx_d    = !debug_en_i || fire || complete ? '0 : byte_in ? idx_q + IW'(1) : idx_q;
      asm_d    = !debug_en_i || fire || complete ? '0 : byte_in ? asm_nxt : asm_q;
      tmo_d    = TIMEOUT_CYC == 0 || !debug_en_i || byte_in || fire || idx_q == '0 ? '0 : tmo_q + TW'(1);
      out_st_d = complete && !full ? FULL : start || accept ? EMPTY : out_st_q;
      data_d   = complete && !full ? asm_nxt : data_q;
      addr_d   = start ? BASE_ADDR : accept ? addr_q + ADDR_W'(NB) : addr_q;
      cnt_d    = start ? '0 : accept ? cnt_q + ADDR_W'(1) : cnt_q;
      done_d   = accept;
      tflag_d  = !start && (tflag_q || fire);
      ovr_d    = !start && (ovr_q || (complete && full));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         col_st_q <= IDLE;
         out_st_q <= EMPTY;
         idx_q    <= '0;
         asm_q    <= '0;
         tmo_q    <= '0;
         data_q   <= '0;
         addr_q   <= BASE_ADDR;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         tflag_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         col_st_q <= col_st_d;
         out_st_q <= out_st_d;
         idx_q    <= idx_d;
         asm_q    <= asm_d;
         tmo_q    <= tmo_d;
         data_q   <= data_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         tflag_q  <= tflag_d;
         ovr_q    <= ovr_d;
      end
   end
   assign req_o       = debug_en_i & ~rst;
   assign wr_valid_o  = out_st_q == FULL;
   assign w_addr      = addr_q;
   assign w_data      = data_q;
   assign word_done_o = done_q;
   assign word_cnt_o  = cnt_q;
   assign timeout_o   = tflag_q;
   assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: directed and random checks of two loader configurations against a queue-based model
module tb_uart_word_loader;
   logic        clk = 1'b0, rst = 1'b1, debug_en = 1'b0, rx_done = 1'b0, wr_ready = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        req0, v0, dn0, t0, o0, req1, v1, dn1, t1, o1;
   logic [31:0] a0, d0, c0, a1, c1;
   logic [15:0] d1;
   int          errors = 0, checks = 0, dones0 = 0;
   logic [7:0]  mq0[$], mq1[$];
   bit          m_en[2], m_valid[2], m_done[2], m_tf[2], m_ov[2];
   logic [63:0] m_data[2];
   logic [31:0] m_addr[2], m_cnt[2];
   int          m_idle[2];

   always #5 clk = ~clk;

   uart_word_loader #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0), .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(10)) dut0 (
      .clk(clk), .rst(rst), .debug_en_i(debug_en), .rx_done_i(rx_done), .rx_data_i(rx_data),
      .req_o(req0), .wr_valid_o(v0), .wr_ready_i(wr_ready), .w_addr(a0), .w_data(d0),
      .word_done_o(dn0), .word_cnt_o(c0), .timeout_o(t0), .overrun_o(o0));

   uart_word_loader #(.DATA_W(16), .ADDR_W(32), .BASE_ADDR(32'h100), .BIG_ENDIAN(1'b0), .TIMEOUT_CYC(0)) dut1 (
      .clk(clk), .rst(rst), .debug_en_i(debug_en), .rx_done_i(rx_done), .rx_data_i(rx_data),
      .req_o(req1), .wr_valid_o(v1), .wr_ready_i(wr_ready), .w_addr(a1), .w_data(d1),
      .word_done_o(dn1), .word_cnt_o(c1), .timeout_o(t1), .overrun_o(o1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural reference: bytes queue up until a word's worth has arrived, then pack.
   task automatic model_step(input int k);
      logic [7:0]  q[$];
      logic [63:0] w;
      logic [31:0] base;
      int          nb, tmo;
      bit          be, start, acc, full;
      nb   = (k == 0) ? 4 : 2;
      be   = (k == 0);
      base = (k == 0) ? 32'h0 : 32'h100;
      tmo  = (k == 0) ? 10 : 0;
      if (k == 0) q = mq0; else q = mq1;
      if (rst) begin
         m_valid[k] = 0; m_addr[k] = base; m_data[k] = '0; m_done[k] = 0; m_cnt[k] = '0;
         m_tf[k] = 0; m_ov[k] = 0; m_idle[k] = 0; m_en[k] = 0; q.delete();
      end else begin
         start = debug_en && !m_en[k];
         acc   = m_valid[k] && wr_ready;
         full  = m_valid[k] && !start && !wr_ready;
         m_done[k] = acc;
         if (start) begin
            m_addr[k] = base; m_cnt[k] = '0; m_tf[k] = 0; m_ov[k] = 0; m_valid[k] = 0;
         end else if (acc) begin
            m_addr[k] = m_addr[k] + 32'(nb); m_cnt[k] = m_cnt[k] + 32'd1; m_valid[k] = 0;
         end
         if (!debug_en) begin
            q.delete(); m_idle[k] = 0;
         end else if (rx_done) begin
            q.push_back(rx_data); m_idle[k] = 0;
            if (q.size() == nb) begin
               w = '0;
               for (int i = 0; i < nb; i++)
                  w = be ? ((w << 8) | 64'(q[i])) : (w | (64'(q[i]) << (8 * i)));
               if (full) m_ov[k] = 1;
               else begin m_data[k] = w; m_valid[k] = 1; end
               q.delete();
            end
         end else if (q.size() != 0 && tmo != 0) begin
            m_idle[k]++;
            if (m_idle[k] == tmo) begin q.delete(); m_tf[k] = 1; m_idle[k] = 0; end
         end
         m_en[k] = debug_en;
      end
      if (k == 0) mq0 = q; else mq1 = q;
   endtask

   task automatic check_all();
      chk("req0", 64'(req0), 64'(debug_en & ~rst));
      chk("valid0", 64'(v0), 64'(m_valid[0]));
      chk("addr0", 64'(a0), 64'(m_addr[0]));
      chk("data0", 64'(d0), m_data[0] & 64'hFFFF_FFFF);
      chk("done0", 64'(dn0), 64'(m_done[0]));
      chk("cnt0", 64'(c0), 64'(m_cnt[0]));
      chk("tmo0", 64'(t0), 64'(m_tf[0]));
      chk("ovr0", 64'(o0), 64'(m_ov[0]));
      chk("req1", 64'(req1), 64'(debug_en & ~rst));
      chk("valid1", 64'(v1), 64'(m_valid[1]));
      chk("addr1", 64'(a1), 64'(m_addr[1]));
      chk("data1", 64'(d1), m_data[1] & 64'hFFFF);
      chk("done1", 64'(dn1), 64'(m_done[1]));
      chk("cnt1", 64'(c1), 64'(m_cnt[1]));
      chk("tmo1", 64'(t1), 64'(m_tf[1]));
      chk("ovr1", 64'(o1), 64'(m_ov[1]));
   endtask

   task automatic tick();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      if (dn0) dones0++;
      check_all();
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic redownload();
      debug_en = 1'b0;
      tick();
      debug_en = 1'b1;
      tick();
   endtask

   initial begin
      tick();
      tick();
      chk("rst_valid", 64'(v0), 64'd0);
      chk("rst_addr0", 64'(a0), 64'd0);
      chk("rst_addr1", 64'(a1), 64'h100);
      chk("rst_cnt", 64'(c0), 64'd0);
      chk("rst_data", 64'(d0), 64'd0);
      rst = 1'b0;
      debug_en = 1'b1;
      tick();
      dones0 = 0;
      send(8'h12); send(8'h34); send(8'h56); send(8'h78);
      chk("w1_data", 64'(d0), 64'h12345678);
      chk("w1_addr", 64'(a0), 64'h0);
      chk("w1_valid", 64'(v0), 64'd1);
      send(8'h9A);
      chk("w1_acc_addr", 64'(a0), 64'h4);
      chk("w1_done", 64'(dn0), 64'd1);
      send(8'hBC); send(8'hDE); send(8'hF0);
      chk("w2_data", 64'(d0), 64'h9ABCDEF0);
      chk("w2_addr", 64'(a0), 64'h4);
      tick();
      chk("w2_cnt", 64'(c0), 64'd2);
      chk("done_pulses", 64'(dones0), 64'd2);
      redownload();
      send(8'hAA); send(8'h55);
      chk("le_data", 64'(d1), 64'h55AA);
      chk("le_addr", 64'(a1), 64'h100);
      tick();
      chk("le_next_addr", 64'(a1), 64'h102);
      redownload();
      wr_ready = 1'b0;
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("ov_data0", 64'(d0), 64'h11223344);
      send(8'h55); send(8'h66); send(8'h77); send(8'h88);
      chk("ov_flag", 64'(o0), 64'd1);
      chk("ov_data", 64'(d0), 64'h11223344);
      chk("ov_addr", 64'(a0), 64'h0);
      wr_ready = 1'b1;
      tick();
      chk("ov_acc_valid", 64'(v0), 64'd0);
      chk("ov_acc_addr", 64'(a0), 64'h4);
      redownload();
      send(8'hA1); send(8'hA2);
      repeat (9) tick();
      send(8'hA3);
      chk("tmo_byte_wins", 64'(t0), 64'd0);
      repeat (9) tick();
      chk("tmo_early", 64'(t0), 64'd0);
      tick();
      chk("tmo_fire", 64'(t0), 64'd1);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      chk("tmo_word", 64'(d0), 64'h01020304);
      chk("tmo_addr", 64'(a0), 64'h0);
      redownload();
      wr_ready = 1'b0;
      send(8'h21); send(8'h22); send(8'h23); send(8'h24);
      send(8'h31); send(8'h32); send(8'h33);
      wr_ready = 1'b1;
      send(8'h34);
      chk("b2b_ovr", 64'(o0), 64'd0);
      chk("b2b_data", 64'(d0), 64'h31323334);
      chk("b2b_addr", 64'(a0), 64'h4);
      tick();
      chk("b2b_addr2", 64'(a0), 64'h8);
      chk("b2b_cnt", 64'(c0), 64'd2);
      wr_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(8'(i + 8'h60));
      chk("mid_ovr_set", 64'(o0), 64'd1);
      send(8'h70); send(8'h71);
      redownload();
      chk("mid_addr", 64'(a0), 64'h0);
      chk("mid_cnt", 64'(c0), 64'd0);
      chk("mid_ovr", 64'(o0), 64'd0);
      chk("mid_valid", 64'(v0), 64'd0);
      send(8'h81); send(8'h82); send(8'h83); send(8'h84); send(8'h85); send(8'h86);
      rst = 1'b1;
      #1;
      chk("rst_req", 64'(req0), 64'd0);
      tick();
      chk("rst_mid_valid", 64'(v0), 64'd0);
      chk("rst_mid_data", 64'(d0), 64'd0);
      chk("rst_mid_addr", 64'(a1), 64'h100);
      rst = 1'b0;
      #1;
      chk("req_follow", 64'(req0), 64'd1);
      wr_ready = 1'b1;
      repeat (500) begin
         if ($urandom_range(0, 39) == 0) debug_en = ~debug_en;
         rst = ($urandom_range(0, 199) == 0);
         wr_ready = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 29) == 0) begin
            rx_done = 1'b0;
            repeat ($urandom_range(8, 12)) tick();
         end
         rx_data = 8'($urandom);
         rx_done = ($urandom_range(0, 99) < 45);
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
